// File: rtl/uart_frame_assembler_if.sv
// rtl/uart_frame_assembler_if.sv - byte-in / payload-out signal bundle for uart_frame_assembler
interface uart_frame_assembler_if #(
    parameter int MAX_LEN = 8
);
    logic [7:0]           rx_msg;
    logic                 rx_complete;
    logic                 msg_ack;
    logic [8*MAX_LEN-1:0] msg_data;
    logic [3:0]           msg_len;
    logic                 msg_valid;
    logic                 err_pulse;
    logic [1:0]           err_code;
    logic                 busy;

    // Upstream byte source and payload consumer side
    modport master (
        output rx_msg, rx_complete, msg_ack,
        input  msg_data, msg_len, msg_valid, err_pulse, err_code, busy
    );

    // Frame assembler side
    modport slave (
        input  rx_msg, rx_complete, msg_ack,
        output msg_data, msg_len, msg_valid, err_pulse, err_code, busy
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// rtl/uart_frame_assembler.sv - assembles SOF/LEN/payload/CHK byte frames into a held payload
module uart_frame_assembler #(
    parameter int          MAX_LEN     = 8,
    parameter int          TIMEOUT_CYC = 8680,
    parameter logic [7:0]  SOF         = 8'h23
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    uart_frame_assembler_if.slave bus
);
    localparam int DW    = 8 * MAX_LEN;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CHK     = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        chk_q, chk_d;
    logic [DW-1:0]     data_q, data_d;
    logic [3:0]        msg_len_q, msg_len_d;
    logic              valid_q, valid_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    logic              byte_in;
    logic [7:0]        rx;
    logic              in_frame;
    logic              timeout;

    assign byte_in  = bus.rx_complete;
    assign rx       = bus.rx_msg;
    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // A byte arriving on the terminal-count cycle takes priority over the timeout
    assign timeout  = in_frame && !byte_in && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

    // Next-state, payload capture, checksum and error generation
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        data_d      = data_q;
        msg_len_d   = msg_len_q;
        valid_d     = valid_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;

        // Inter-byte timer only runs while a frame is partially received
        if (in_frame && !byte_in) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (byte_in && rx == SOF) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end else if (byte_in) begin
                    if (rx == 8'd0 || rx > 8'(MAX_LEN)) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = rx[3:0];
                        chk_d   = rx;
                        cnt_d   = '0;
                        data_d  = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end else if (byte_in) begin
                    // SOF here is plain data; no resynchronisation mid-frame
                    data_d[8*cnt_q +: 8] = rx;
                    chk_d                = chk_q ^ rx;
                    if (cnt_q == len_q - 4'd1) begin
                        state_d = S_CHK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_CHK: begin
                if (timeout) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end else if (byte_in) begin
                    if (rx == chk_q) begin
                        msg_len_d = len_q;
                        valid_d   = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_HOLD: begin
                // Payload is frozen; any byte now is lost, even alongside an ack
                if (byte_in) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (bus.msg_ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            data_q      <= '0;
            msg_len_q   <= '0;
            valid_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            data_q      <= data_d;
            msg_len_q   <= msg_len_d;
            valid_q     <= valid_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            tmr_q       <= tmr_d;
        end
    end

    assign bus.msg_data  = data_q;
    assign bus.msg_len   = msg_len_q;
    assign bus.msg_valid = valid_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = in_frame;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb/tb_uart_frame_assembler.sv - scoreboard bench for uart_frame_assembler
module tb_uart_frame_assembler;
    localparam int MAX_LEN = 8;
    localparam int TO      = 8680;

    typedef struct {
        logic [3:0]  len;
        logic [63:0] data;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    uart_frame_assembler_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_assembler #(
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TO),
        .SOF        (8'h23)
    ) dut (
        .clk_50M(clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    frame_t     exp_frames[$];
    logic [1:0] exp_errs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop expected payloads on msg_valid rise, expected codes on err_pulse
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    always @(negedge clk) begin : monitor
        frame_t f;
        if (bus.msg_valid && !prev_valid) begin
            if (exp_frames.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                f = exp_frames.pop_front();
                check("msg_len", bus.msg_len, f.len);
                check("msg_data", bus.msg_data, f.data);
            end
        end
        if (bus.err_pulse) begin
            check("err_width", prev_err, 0);
            if (exp_errs.size() == 0) begin
                check("err_unexpected", 1, 0);
            end else begin
                check("err_code", bus.err_code, exp_errs.pop_front());
            end
        end
        prev_valid <= bus.msg_valid;
        prev_err   <= bus.err_pulse;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_msg      = b;
        bus.rx_complete = 1'b1;
        @(negedge clk);
        bus.rx_complete = 1'b0;
        bus.rx_msg      = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic good_frame(input int len, input logic [63:0] payload, input int gap);
        frame_t     f;
        logic [7:0] chk;
        logic [63:0] masked;
        masked = '0;
        chk    = 8'(len);
        for (int i = 0; i < len; i++) begin
            masked[8*i +: 8] = payload[8*i +: 8];
            chk = chk ^ payload[8*i +: 8];
        end
        f.len  = 4'(len);
        f.data = masked;
        exp_frames.push_back(f);
        send_byte(8'h23, gap);
        send_byte(8'(len), gap);
        for (int i = 0; i < len; i++) send_byte(payload[8*i +: 8], gap);
        send_byte(chk, 0);
        check("valid_latency", bus.msg_valid, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.msg_ack = 1'b1;
        @(negedge clk);
        bus.msg_ack = 1'b0;
        check("ack_drop", bus.msg_valid, 0);
    endtask

    initial begin : stim
        frame_t f;
        logic   stable;
        int     n;

        bus.rx_msg      = 8'h00;
        bus.rx_complete = 1'b0;
        bus.msg_ack     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_valid", bus.msg_valid, 0);
        check("rst_data", bus.msg_data, 0);
        check("rst_len", bus.msg_len, 0);
        check("rst_err_pulse", bus.err_pulse, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        // Spec frame with wide byte spacing, then a long unacknowledged hold
        f.len  = 4'd3;
        f.data = 64'h434241;
        exp_frames.push_back(f);
        send_byte(8'h23, 4340);
        check("busy_in_len", bus.busy, 1);
        send_byte(8'h03, 4340);
        send_byte(8'h41, 4340);
        send_byte(8'h42, 4340);
        send_byte(8'h43, 4340);
        send_byte(8'h43, 0);
        check("valid_latency", bus.msg_valid, 1);
        check("busy_in_hold", bus.busy, 0);
        stable = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (bus.msg_valid !== 1'b1 || bus.msg_data !== 64'h434241 || bus.msg_len !== 4'd3)
                stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        ack();

        // Garbage before SOF is dropped silently
        send_byte(8'h55, 5);
        send_byte(8'hAA, 5);
        check("garbage_busy", bus.busy, 0);
        good_frame(1, 64'h7E, 5);
        ack();

        // Bad checksum
        exp_errs.push_back(2'b10);
        send_byte(8'h23, 3);
        send_byte(8'h02, 3);
        send_byte(8'h10, 3);
        send_byte(8'h20, 3);
        send_byte(8'h31, 0);
        check("badchk_busy", bus.busy, 0);
        check("badchk_valid", bus.msg_valid, 0);
        repeat (3) @(negedge clk);

        // Bad lengths: zero and MAX_LEN+1, then a full-size good frame
        exp_errs.push_back(2'b01);
        send_byte(8'h23, 3);
        send_byte(8'h00, 3);
        exp_errs.push_back(2'b01);
        send_byte(8'h23, 3);
        send_byte(8'h09, 3);
        check("badlen_busy", bus.busy, 0);
        good_frame(MAX_LEN, {$urandom, $urandom}, 2);
        ack();

        // Inter-byte timeout measured from the last strobe
        exp_errs.push_back(2'b00);
        send_byte(8'h23, 3);
        send_byte(8'h02, 3);
        send_byte(8'h10, 0);
        n = 0;
        while (bus.err_pulse !== 1'b1 && n < TO + 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_busy", bus.busy, 0);
        repeat (3) @(negedge clk);

        // Byte arriving on the terminal-count cycle beats the timeout
        f.len  = 4'd1;
        f.data = 64'h55;
        exp_frames.push_back(f);
        send_byte(8'h23, 3);
        send_byte(8'h01, TO - 2);
        send_byte(8'h55, TO - 2);
        send_byte(8'h54, 0);
        check("tc_valid", bus.msg_valid, 1);
        ack();

        // Overrun while holding, then ack and byte in the same cycle
        good_frame(2, 64'hBEEF, 2);
        exp_errs.push_back(2'b11);
        send_byte(8'h23, 3);
        check("overrun_valid", bus.msg_valid, 1);
        check("overrun_data", bus.msg_data, 64'hBEEF);
        exp_errs.push_back(2'b11);
        @(negedge clk);
        bus.msg_ack     = 1'b1;
        bus.rx_complete = 1'b1;
        bus.rx_msg      = 8'h23;
        @(negedge clk);
        bus.msg_ack     = 1'b0;
        bus.rx_complete = 1'b0;
        bus.rx_msg      = 8'h00;
        check("ackrx_valid", bus.msg_valid, 0);
        check("ackrx_code", bus.err_code, 2'b11);
        repeat (3) @(negedge clk);
        check("ackrx_busy", bus.busy, 0);

        // Asynchronous reset mid-payload
        send_byte(8'h23, 3);
        send_byte(8'h03, 3);
        send_byte(8'h41, 3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_data", bus.msg_data, 0);
        check("arst_len", bus.msg_len, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_code", bus.err_code, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h42, 5);
        check("post_rst_busy", bus.busy, 0);
        good_frame(3, 64'hC0FFEE, 3);
        ack();

        repeat (10) @(negedge clk);
        check("frames_left", exp_frames.size(), 0);
        check("errs_left", exp_errs.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
